// File: rtl/gppcu_instr_issuer_pkg.sv
// Shared types for the GPPCU instruction issuer.
// Holds the FSM state encoding and FIFO count sizing.
package gppcu_instr_issuer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Count must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gppcu_sync_fifo.sv
// Prefetch FIFO: registered storage, head visible combinationally.
// Push into an empty FIFO shows up the following cycle.
module gppcu_sync_fifo
  import gppcu_instr_issuer_pkg::*;
#(
  parameter int DBW = 32,
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  logic [DBW-1:0] wdata,
  output logic [DBW-1:0] rdata,
  output logic [CW-1:0]  count,
  output logic           empty,
  output logic           full
);

  localparam int AW = $clog2(DEPTH);

  logic [DBW-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wp_q;
  logic [AW-1:0]  rp_q;
  logic [CW-1:0]  cnt_q;
  logic           wr;
  logic           rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign rdata = mem_q[rp_q];
  assign count = cnt_q;

  // Pointers, occupancy and storage; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) begin
        mem_q[wp_q] <= wdata;
        wp_q        <= wp_q + AW'(1);
      end
      if (rd) begin
        rp_q <= rp_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end

endmodule

// File: rtl/gppcu_instr_issuer.sv
// GPPCU instruction issuer: IMEM prefetch -> FIFO -> core handshake.
// Optional multi-pass support under GPPCU_ISSUER_REPEAT_EN.
module gppcu_instr_issuer
  import gppcu_instr_issuer_pkg::*;
#(
  parameter int DBW = 32,
  parameter int IABW = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            iACLK,
  input  logic            inRST,
  input  logic            iSTART,
  input  logic            iABORT,
  input  logic [IABW-1:0] iPROG_BASE,
  input  logic [IABW-1:0] iPROG_LEN,
`ifdef GPPCU_ISSUER_REPEAT_EN
  input  logic [7:0]      iREPEAT,
`endif
  output logic            oBUSY,
  output logic            oDONE,
  output logic [IABW-1:0] oIMEM_ADDR,
  output logic            oIMEM_RD,
  input  logic [DBW-1:0]  iIMEM_RDATA,
  output logic [DBW-1:0]  oINSTR,
  output logic            oINSTR_VALID,
  input  logic            iINSTR_READY
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [CW:0] DEP = (CW+1)'(FIFO_DEPTH);

  state_e          st_q, st_d;
  logic [IABW-1:0] addr_q, addr_d;
  logic [IABW-1:0] rem_q, rem_d;
  logic            infl_q;
  logic            done_q, done_d;
`ifdef GPPCU_ISSUER_REPEAT_EN
  logic [IABW-1:0] base_q, base_d;
  logic [IABW-1:0] len_q, len_d;
  logic [7:0]      rep_q, rep_d;
`endif

  logic          f_pop;
  logic          f_empty;
  logic          f_full;
  logic [CW-1:0] f_cnt;
  logic [CW:0]   occ;
  logic          rd;
  logic          drained;

  gppcu_sync_fifo #(
    .DBW   (DBW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iACLK),
    .rst_n (inRST),
    .push  (infl_q),
    .pop   (f_pop),
    .flush (iABORT),
    .wdata (iIMEM_RDATA),
    .rdata (oINSTR),
    .count (f_cnt),
    .empty (f_empty),
    .full  (f_full)
  );

  // Buffered plus in-flight words bound further reads.
  assign occ   = {1'b0, f_cnt} + {{CW{1'b0}}, infl_q};
  assign rd    = (st_q == ST_RUN) && (rem_q != '0)
               && !f_full && (occ < DEP);
  assign f_pop = ~f_empty & iINSTR_READY;
  // FIFO is empty now or after this cycle's pop.
  assign drained = f_empty
                 | ((f_cnt == CW'(1)) & f_pop);

  assign oIMEM_RD     = rd;
  assign oIMEM_ADDR   = addr_q;
  assign oINSTR_VALID = ~f_empty;
  assign oBUSY        = (st_q != ST_IDLE);
  assign oDONE        = done_q;

  // Next state, counters and completion pulse.
  always_comb begin
    st_d   = st_q;
    addr_d = addr_q;
    rem_d  = rem_q;
    done_d = 1'b0;
`ifdef GPPCU_ISSUER_REPEAT_EN
    base_d = base_q;
    len_d  = len_q;
    rep_d  = rep_q;
`endif
    unique case (st_q)
      ST_IDLE: begin
        if (iSTART) begin
          addr_d = iPROG_BASE;
          rem_d  = iPROG_LEN;
`ifdef GPPCU_ISSUER_REPEAT_EN
          base_d = iPROG_BASE;
          len_d  = iPROG_LEN;
          rep_d  = iREPEAT;
`endif
          if (iPROG_LEN != '0) begin
            st_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (rd) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == IABW'(1)) begin
`ifdef GPPCU_ISSUER_REPEAT_EN
            if (rep_q != '0) begin
              addr_d = base_q;
              rem_d  = len_q;
              rep_d  = rep_q - 8'd1;
            end else begin
              st_d = ST_DRAIN;
            end
`else
            st_d = ST_DRAIN;
`endif
          end
        end
      end
      ST_DRAIN: begin
        if (!infl_q && drained) begin
          st_d   = ST_IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (iABORT) begin
      st_d   = ST_IDLE;
      done_d = 1'b0;
    end
  end

  // State, counters and read-in-flight flag.
  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      st_q   <= ST_IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      infl_q <= 1'b0;
      done_q <= 1'b0;
`ifdef GPPCU_ISSUER_REPEAT_EN
      base_q <= '0;
      len_q  <= '0;
      rep_q  <= '0;
`endif
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      rem_q  <= rem_d;
      infl_q <= rd & ~iABORT;
      done_q <= done_d;
`ifdef GPPCU_ISSUER_REPEAT_EN
      base_q <= base_d;
      len_q  <= len_d;
      rep_q  <= rep_d;
`endif
    end
  end

endmodule
